// File: rtl/load_store_unit_if.sv
// Datapath/memory-facing bus of the OTTER load/store unit.
// The unit uses the slave view; the environment (datapath plus memory) uses the master view.
interface load_store_unit_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [BUS_WIDTH-1:0] req_addr;
  logic [BUS_WIDTH-1:0] req_wdata;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic                 resp_valid;
  logic [BUS_WIDTH-1:0] resp_rdata;
  logic                 resp_fault;
  logic                 mem_rd;
  logic                 mem_we;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic [BUS_WIDTH-1:0] mem_data;
  logic [1:0]           mem_size;
  logic [BUS_WIDTH-1:0] mem_out;
  logic                 mem_error;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  mem_out, mem_error,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_rd, mem_we, mem_addr, mem_data, mem_size
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output mem_out, mem_error,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_rd, mem_we, mem_addr, mem_data, mem_size
  );
endinterface

// File: rtl/load_store_unit.sv
// OTTER data-memory initiator: one request at a time, lane-aligned stores,
// extracted and extended loads, single-cycle response with fault flag.
module load_store_unit #(
  parameter int BUS_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic                 accept;
  logic                 we_q, uns_q, fault_q;
  logic [1:0]           size_q;
  logic [BUS_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [BUS_WIDTH-1:0] ld_ext;

  always_comb accept = bus.req_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.req_size == 2'b11) ? RESP : ACCESS;
      ACCESS:  state_nxt = (bus.mem_error || we_q) ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_fault = fault_q;
    bus.mem_rd     = (state == ACCESS) && !we_q && !bus.mem_error;
    bus.mem_we     = (state == ACCESS) &&  we_q && !bus.mem_error;
    bus.mem_addr   = addr_q;
    bus.mem_size   = size_q;
    case (size_q)
      2'b00:   bus.mem_data = {4{wdata_q[7:0]}};
      2'b01:   bus.mem_data = {2{wdata_q[15:0]}};
      default: bus.mem_data = wdata_q;
    endcase
  end

  always_comb begin
    ld_byte = bus.mem_out[{addr_q[1:0], 3'b000} +: 8];
    ld_half = bus.mem_out[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = bus.mem_out;
    endcase
  end

  // Response fields are only rewritten on the way into RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      case (state)
        IDLE: if (accept && bus.req_size == 2'b11) begin
          fault_q <= 1'b1;
          rdata_q <= '0;
        end
        ACCESS: if (bus.mem_error || we_q) begin
          fault_q <= bus.mem_error;
          rdata_q <= '0;
        end
        WAIT: begin
          fault_q <= 1'b0;
          rdata_q <= ld_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written reset/busy sequences,
// and random traffic checked against a byte-array reference model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.BUS_WIDTH(32)) bus ();

  load_store_unit #(.BUS_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word-organised memory with byte enables and an alignment error output.
  logic [31:0] mem [0:255];
  logic [3:0]  be;
  logic [7:0]  idx;

  always_comb begin
    idx = bus.mem_addr[9:2];
    bus.mem_error = (bus.mem_size == 2'b11) ||
                    (bus.mem_size == 2'b01 && bus.mem_addr[0]) ||
                    (bus.mem_size == 2'b10 && bus.mem_addr[1:0] != 2'b00);
    case (bus.mem_size)
      2'b00:   be = 4'b0001 << bus.mem_addr[1:0];
      2'b01:   be = bus.mem_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.mem_we && !bus.mem_error) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= bus.mem_data[8*i +: 8];
    end
    if (bus.mem_rd) bus.mem_out <= mem[idx];
  end

  // Reference model: flat byte memory, spec-level rules.
  logic [7:0] ref_mem [0:1023];

  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic fault, output logic [31:0] rdata, output int lat,
                       output logic [31:0] md);
    int n;
    logic [31:0] v;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    fault = (size == 2'b11) || (addr % n != 0);
    rdata = '0;
    md = '0;
    for (int i = 0; i < 4; i++) md[8*i +: 8] = wdata[8*(i % n) +: 8];
    if (size == 2'b11)  lat = 1;
    else if (fault || we) lat = 2;
    else lat = 3;
    if (!fault && we) begin
      for (int i = 0; i < n; i++) ref_mem[addr[9:0] + 10'(i)] = wdata[8*i +: 8];
    end else if (!fault) begin
      v = '0;
      for (int i = 0; i < n; i++) v = v + (32'(ref_mem[addr[9:0] + 10'(i)]) << (8*i));
      if (!uns && v[8*n-1]) v = v - (32'd1 << (8*n)) * ((n == 4) ? 0 : 1);
      rdata = v;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " req_ready"},  32'(bus.req_ready),  32'd1);
    chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, " resp_fault"}, 32'(bus.resp_fault), 32'd0);
    chk({tag, " resp_rdata"}, bus.resp_rdata,      32'd0);
    chk({tag, " mem_rd"},     32'(bus.mem_rd),     32'd0);
    chk({tag, " mem_we"},     32'(bus.mem_we),     32'd0);
    chk({tag, " mem_addr"},   bus.mem_addr,        32'd0);
    chk({tag, " mem_data"},   bus.mem_data,        32'd0);
    chk({tag, " mem_size"},   32'(bus.mem_size),   32'd0);
  endtask

  // One complete transaction: handshake, bounded wait for resp_valid, then all checks.
  task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input logic exp_fault, input logic [31:0] exp_rdata,
                         input int exp_lat, input logic [31:0] exp_md);
    int lat, rd_cnt, we_cnt;
    logic [31:0] md_seen;
    @(negedge clk);
    chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;  bus.req_we = we;  bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_size = size; bus.req_unsigned = uns;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1; rd_cnt = 0; we_cnt = 0; md_seen = '0;
    while (!bus.resp_valid && lat < 10) begin
      if (bus.mem_rd) rd_cnt++;
      if (bus.mem_we) begin we_cnt++; md_seen = bus.mem_data; end
      @(negedge clk);
      lat++;
    end
    chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, " latency"},    32'(lat),            32'(exp_lat));
    chk({tag, " fault"},      32'(bus.resp_fault), 32'(exp_fault));
    chk({tag, " rdata"},      bus.resp_rdata,      exp_rdata);
    chk({tag, " rd pulses"},  32'(rd_cnt),         32'(!we && !exp_fault));
    chk({tag, " we pulses"},  32'(we_cnt),         32'(we && !exp_fault));
    if (we && !exp_fault) chk({tag, " mem_data"}, md_seen, exp_md);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        fault;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] md;
  } vec_t;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vt [13];
    logic        r_we, r_uns, e_fault;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, e_rdata, e_md;
    int          e_lat;

    vt[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h0,        2, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 3, 32'h0};
    vt[2]  = '{1'b1, 32'h103, 32'h00000080, 2'b00, 1'b0, 1'b0, 32'h0,        2, 32'h80808080};
    vt[3]  = '{1'b0, 32'h103, 32'h0,        2'b00, 1'b0, 1'b0, 32'hFFFFFF80, 3, 32'h0};
    vt[4]  = '{1'b0, 32'h103, 32'h0,        2'b00, 1'b1, 1'b0, 32'h00000080, 3, 32'h0};
    vt[5]  = '{1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 1'b0, 32'h80ADBEEF, 3, 32'h0};
    vt[6]  = '{1'b1, 32'h202, 32'h00008001, 2'b01, 1'b0, 1'b0, 32'h0,        2, 32'h80018001};
    vt[7]  = '{1'b0, 32'h202, 32'h0,        2'b01, 1'b0, 1'b0, 32'hFFFF8001, 3, 32'h0};
    vt[8]  = '{1'b0, 32'h202, 32'h0,        2'b01, 1'b1, 1'b0, 32'h00008001, 3, 32'h0};
    vt[9]  = '{1'b0, 32'h101, 32'h0,        2'b10, 1'b0, 1'b1, 32'h0,        2, 32'h0};
    vt[10] = '{1'b1, 32'h101, 32'h12345678, 2'b10, 1'b0, 1'b1, 32'h0,        2, 32'h0};
    vt[11] = '{1'b1, 32'h104, 32'h55555555, 2'b11, 1'b0, 1'b1, 32'h0,        1, 32'h0};
    vt[12] = '{1'b0, 32'h104, 32'h0,        2'b11, 1'b1, 1'b1, 32'h0,        1, 32'h0};

    rst_n = 1'b0; mem_clr = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_size = '0; bus.req_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1; mem_clr = 1'b0;

    for (int i = 0; i < 13; i++)
      run_req($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size,
              vt[i].uns, vt[i].fault, vt[i].rdata, vt[i].lat, vt[i].md);

    // Reset during the WAIT cycle of a load drops the response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h100;
    bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state("midreset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midreset quiet%0d", i), 32'(bus.resp_valid), 32'd0);
    end

    // req_valid held through a busy store is taken only once the unit is idle again.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h104;
    bus.req_wdata = 32'hCAFEF00D; bus.req_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_wdata = '0;
    chk("busy access ready", 32'(bus.req_ready), 32'd0);
    chk("busy access we",    32'(bus.mem_we),    32'd1);
    @(negedge clk);
    chk("busy resp valid",   32'(bus.resp_valid), 32'd1);
    chk("busy resp ready",   32'(bus.req_ready),  32'd0);
    @(negedge clk);
    chk("busy idle ready",   32'(bus.req_ready),  32'd1);
    chk("busy idle valid",   32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("held load rd",      32'(bus.mem_rd),     32'd1);
    chk("held load c1 valid",32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk("held load c2 valid",32'(bus.resp_valid), 32'd0);
    chk("held load c2 rd",   32'(bus.mem_rd),     32'd0);
    @(negedge clk);
    chk("held load resp",    32'(bus.resp_valid), 32'd1);
    chk("held load rdata",   bus.resp_rdata,      32'hCAFEF00D);
    @(negedge clk);
    chk("held load after",   32'(bus.resp_valid), 32'd0);

    // Random traffic against the byte-array model, starting from cleared memories.
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    for (int t = 0; t < 300; t++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_uns   = 1'($urandom_range(0, 1));
      r_size  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_addr  = 32'($urandom_range(0, 127));
      r_wdata = $urandom;
      if (r_size != 2'b11 && $urandom_range(0, 3) != 0)
        r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      model(r_we, r_addr, r_wdata, r_size, r_uns, e_fault, e_rdata, e_lat, e_md);
      run_req($sformatf("rnd%0d", t), r_we, r_addr, r_wdata, r_size, r_uns,
              e_fault, e_rdata, e_lat, e_md);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
